// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iteration sequencer for a 32-bit CORDIC x/y/z add/sub datapath
module cordic_iter_ctrl #(
    parameter int ITERS = 16,
    parameter int CW    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic          i_hold,
    input  logic          i_y_msb,
    input  logic          i_z_msb,
    output logic          o_load,
    output logic          o_ce,
    output logic          o_cin_x,
    output logic          o_cin_y,
    output logic          o_cin_z,
    output logic [CW-1:0] o_shift,
    output logic [CW-1:0] o_atan_addr,
    output logic          o_mode_q,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_i;
    logic [CW-1:0] w_i_next;
    logic          r_mode_q;
    logic          w_mode_next;
    logic          w_dpos;
    logic          w_last;

    // Vectoring drives y toward zero, rotation drives z toward zero.
    assign w_dpos   = r_mode_q ? i_y_msb : ~i_z_msb;
    assign w_last   = (r_i == CW'(ITERS - 1));
    assign o_mode_q = r_mode_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_i      <= '0;
            r_mode_q <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_i      <= w_i_next;
            r_mode_q <= w_mode_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_i_next    = r_i;
        w_mode_next = r_mode_q;
        o_load      = 1'b0;
        o_ce        = 1'b0;
        o_cin_x     = 1'b0;
        o_cin_y     = 1'b0;
        o_cin_z     = 1'b0;
        o_shift     = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next      = S_LOAD;
                    w_mode_next = i_mode;
                end
            end
            S_LOAD: begin
                o_load   = 1'b1;
                o_ce     = 1'b1;
                o_busy   = 1'b1;
                w_i_next = '0;
                w_next   = S_ITER;
            end
            S_ITER: begin
                o_busy  = 1'b1;
                o_shift = r_i;
                if (!i_hold) begin
                    o_ce    = 1'b1;
                    o_cin_x = w_dpos;
                    o_cin_y = ~w_dpos;
                    o_cin_z = w_dpos;
                    // Counter returns to 0 on exit so it never exceeds ITERS-1.
                    if (w_last) begin
                        w_i_next = '0;
                        w_next   = S_DONE;
                    end else begin
                        w_i_next = r_i + CW'(1);
                    end
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next   = S_IDLE;
                w_i_next = '0;
            end
        endcase
        o_atan_addr = o_shift;
    end

endmodule
